// File: rtl/shift_operand_stage.sv
// ---------------------------------------------------------------------------
// shift_operand_stage
//   Operand-2 stage sitting between register-file read and the barrel shifter.
//   Decodes the ARM data-processing operand-2 field of the accepted instruction
//   and holds the shifter controls (enable, direction, data, amount) in
//   registers until the downstream stage consumes them. Register-specified
//   shifts spend one extra cycle (RS_WAIT) collecting Rs from the read port.
//
// State table
//   state   | meaning
//   EMPTY   | no operation held; ready for a new instruction
//   RS_WAIT | register-shift op latched, capturing Rs[7:0] as the amount
//   FULL    | shifter controls valid, waiting for out_ready
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              synchronous pipeline flush, overrides everything but rst
//   in_valid/in_ready  handshake with the decode stage
//   instr, rm_data     instruction word and Rm value, valid with in_valid
//   rs_data            Rs value, valid the cycle after a register-shift accept
//   rs_req             Rs read port in use (RS_WAIT)
//   out_valid/out_ready handshake with the shifter/ALU stage
//   sh_enable          shifter enable
//   sh_control         0 = LSL, 1 = LSR
//   sh_in_data         data to shift
//   sh_shift_amt       shift amount, zero-extended
//   sh_unsup           ASR/ROR encoding, not supported by the shifter
// ---------------------------------------------------------------------------
module shift_operand_stage #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [DATA_W-1:0] rs_data,
  output logic              rs_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sh_enable,
  output logic              sh_control,
  output logic [DATA_W-1:0] sh_in_data,
  output logic [AMT_W-1:0]  sh_shift_amt,
  output logic              sh_unsup
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    RS_WAIT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              is_imm;
  logic              is_reg;
  logic              lsr_32;
  logic [AMT_W-1:0]  imm_amt;

  // Bits of the instruction and Rs that this stage never looks at.
  logic              unused_bits;
  assign unused_bits = ^{instr[31:26], instr[24:12], rs_data[DATA_W-1:8]};

  assign out_valid = (state == FULL);
  assign rs_req    = (state == RS_WAIT);

  always_comb begin
    in_ready = !flush && ((state == EMPTY) || ((state == FULL) && out_ready));
    accept   = in_valid && in_ready;
    is_imm   = instr[25];
    is_reg   = !instr[25] && instr[4];
    // LSR with a zero imm5 encodes LSR #32.
    lsr_32   = (instr[6:5] == 2'b01) && (instr[11:7] == 5'd0);
    imm_amt  = lsr_32 ? AMT_W'(32) : AMT_W'(instr[11:7]);
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state_nxt = is_reg ? RS_WAIT : FULL;
        end
        RS_WAIT: begin
          state_nxt = FULL;
        end
        FULL: begin
          if (out_ready) begin
            if (accept) state_nxt = is_reg ? RS_WAIT : FULL;
            else        state_nxt = EMPTY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Shifter controls load only on accept (and the amount in RS_WAIT), so they
  // stay frozen while FULL waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_enable    <= 1'b0;
      sh_control   <= 1'b0;
      sh_in_data   <= '0;
      sh_shift_amt <= '0;
      sh_unsup     <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        if (is_imm) begin
          sh_enable    <= 1'b0;
          sh_control   <= 1'b0;
          sh_in_data   <= DATA_W'(instr[7:0]);
          sh_shift_amt <= '0;
          sh_unsup     <= 1'b0;
        end else begin
          sh_enable    <= !instr[6];
          sh_control   <= instr[5];
          sh_in_data   <= rm_data;
          sh_unsup     <= instr[6];
          if (!is_reg) sh_shift_amt <= imm_amt;
        end
      end else if (state == RS_WAIT) begin
        sh_shift_amt <= AMT_W'(rs_data[7:0]);
      end
    end
  end

endmodule
